// File: rtl/fp16_accum_sched.sv
// fp16_accum_sched: reduces a stream of FP16 values to their sum through one shared
// pipelined adder, pairing partial sums from a result FIFO with a one-entry hold register.
module fp16_accum_sched #(
  parameter int ADD_LAT    = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  input  logic [15:0]      in_data,
  output logic             in_ready,
  output logic             add_a_tvalid,
  output logic [15:0]      add_a_tdata,
  output logic             add_b_tvalid,
  output logic [15:0]      add_b_tdata,
  input  logic             add_re_tvalid,
  input  logic [15:0]      add_re_tdata,
  output logic             sum_valid,
  output logic [15:0]      sum_data,
  input  logic             sum_ready
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int SUM_W = PTR_W + 2;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int LAT_W = (ADD_LAT > 0) ? $clog2(ADD_LAT + 1) : 1;

  localparam logic [1:0] S_FLUSH = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [LAT_W-1:0] flush_cnt;
  logic [LEN_W-1:0] rem;
  logic [LEN_W-1:0] fl;
  logic [15:0]      rf_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr_p1;
  logic [CNT_W-1:0] rf_cnt;
  logic             h_valid;
  logic [15:0]      h_data;

  logic             run;
  logic             in_fire;
  logic             rf_push;
  logic             issue;
  logic             h_clr;
  logic             h_load;
  logic             done_now;
  logic [1:0]       pop_n;
  logic [15:0]      op_a;
  logic [15:0]      op_b;
  logic [15:0]      rf_head;
  logic [15:0]      rf_next;

  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [1:0] n);
    logic [SUM_W-1:0] s;
    s = {2'b00, p} + {{PTR_W{1'b0}}, n};
    if (s >= SUM_W'(FIFO_DEPTH)) s = s - SUM_W'(FIFO_DEPTH);
    return s[PTR_W-1:0];
  endfunction

  assign busy      = (state != S_IDLE);
  assign rd_ptr_p1 = ptr_add(rd_ptr, 2'd1);

  // Issue selection works off the registered FIFO count; every accepted sample is consumed the same cycle.
  always_comb begin
    run      = (state == S_RUN);
    in_ready = run && (rem != '0) && (rf_cnt < CNT_W'(2)) &&
               !((rf_cnt == CNT_W'(1)) && h_valid);
    in_fire  = in_valid && in_ready;
    rf_push  = run && add_re_tvalid;
    rf_head  = rf_mem[rd_ptr];
    rf_next  = rf_mem[rd_ptr_p1];
    issue    = 1'b0;
    pop_n    = 2'd0;
    h_clr    = 1'b0;
    h_load   = 1'b0;
    op_a     = rf_head;
    op_b     = rf_next;
    if (run) begin
      if (rf_cnt >= CNT_W'(2)) begin
        issue = 1'b1;
        pop_n = 2'd2;
      end else if ((rf_cnt == CNT_W'(1)) && h_valid) begin
        issue = 1'b1;
        pop_n = 2'd1;
        op_b  = h_data;
        h_clr = 1'b1;
      end else if ((rf_cnt == CNT_W'(1)) && in_fire) begin
        issue = 1'b1;
        pop_n = 2'd1;
        op_b  = in_data;
      end else if (in_fire && h_valid) begin
        issue = 1'b1;
        op_a  = h_data;
        op_b  = in_data;
        h_clr = 1'b1;
      end else if (in_fire) begin
        h_load = 1'b1;
      end
    end
    done_now = run && (rem == '0) && (fl == '0) &&
               (((rf_cnt == CNT_W'(1)) && !h_valid) || ((rf_cnt == '0) && h_valid));
  end

  always_ff @(posedge clk) begin
    if (rf_push) rf_mem[wr_ptr] <= add_re_tdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_FLUSH;
      flush_cnt    <= LAT_W'(ADD_LAT);
      rem          <= '0;
      fl           <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      rf_cnt       <= '0;
      h_valid      <= 1'b0;
      h_data       <= '0;
      add_a_tvalid <= 1'b0;
      add_b_tvalid <= 1'b0;
      add_a_tdata  <= '0;
      add_b_tdata  <= '0;
      sum_valid    <= 1'b0;
      sum_data     <= '0;
    end else begin
      add_a_tvalid <= issue;
      add_b_tvalid <= issue;
      if (issue) begin
        add_a_tdata <= op_a;
        add_b_tdata <= op_b;
      end
      if (rf_push) wr_ptr <= ptr_add(wr_ptr, 2'd1);
      if (pop_n != 2'd0) rd_ptr <= ptr_add(rd_ptr, pop_n);
      rf_cnt <= rf_cnt + CNT_W'(rf_push) - CNT_W'(pop_n);
      if (issue && !rf_push) fl <= fl + LEN_W'(1);
      else if (!issue && rf_push) fl <= fl - LEN_W'(1);
      if (h_load) begin
        h_valid <= 1'b1;
        h_data  <= in_data;
      end else if (h_clr) begin
        h_valid <= 1'b0;
      end
      if (in_fire) rem <= rem - LEN_W'(1);

      // Results still draining from the adder after reset are dropped while in FLUSH.
      case (state)
        S_FLUSH: begin
          if (flush_cnt <= LAT_W'(1)) state <= S_IDLE;
          if (flush_cnt != '0) flush_cnt <= flush_cnt - LAT_W'(1);
        end
        S_IDLE: begin
          if (start) begin
            if (len == '0) begin
              state     <= S_DONE;
              sum_valid <= 1'b1;
              sum_data  <= '0;
            end else begin
              state <= S_RUN;
              rem   <= len;
            end
          end
        end
        S_RUN: begin
          if (done_now) begin
            state     <= S_DONE;
            sum_valid <= 1'b1;
            sum_data  <= h_valid ? h_data : rf_head;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            rf_cnt    <= '0;
            h_valid   <= 1'b0;
          end
        end
        S_DONE: begin
          if (sum_ready) begin
            state     <= S_IDLE;
            sum_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  a_rf_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(rf_push && (pop_n == 2'd0) && (rf_cnt == CNT_W'(FIFO_DEPTH))));

endmodule
